spike_vote_classifier: RTL and testbench
========================================

Name: spike_vote_classifier

Overview:
- Downstream consumer of the RBM core's classifier spike stream.
- Over a programmed number of stochastic iterations, counts one spike vote per class per pass.
- Then scans the counters sequentially for the argmax.
- Presents the winning digit label with a valid/ready handshake. This replaces the bench-side OutputData accumulation and argmax with synthesizable RTL.

Parameters:
- NUM_CLASSES, 10, number of output classes (spike neurons).
- CLASS_W, 4, width of class index (must satisfy 2^CLASS_W >= NUM_CLASSES).
- COUNT_W, 8, width of each per-class vote counter (saturating).
- ITER_W, 8, width of iteration-count configuration.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: begin a new image; honoured only in IDLE.
- iter_num  input  ITER_W  iterations per image, latched on accepted start.
- spike_valid  input  1  spike/spike_class qualify this cycle.
- spike  input  1  classifier neuron output (1 = fired).
- spike_class  input  CLASS_W  class index of the current spike.
- iter_done  input  1  one-cycle pulse: one full pass over all classes finished.
- busy  output  1  high in ACCUM and ARGMAX.
- label_valid  output  1  result available.
- label_ready  input  1  consumer accepts result.
- label  output  CLASS_W  winning class index.
- label_count  output  COUNT_W  vote count of the winner.
- tie  output  1  another class equals the winning count.
- err  output  1  sticky: out-of-range spike_class seen since last accepted start.

Behaviour:
- Reset value of every output is 0; on reset all outputs go to 0, all counters and iteration counter clear, state goes to IDLE. This applies from any state, including mid-ACCUM and mid-ARGMAX.
- States: IDLE, ACCUM, ARGMAX, HOLD.
- IDLE:
  - start=1: clear all counters, tie and err.
  - Latch iter_lat = iter_num, except iter_num = 0 latches 1.
  - iter_cnt = 0; go to ACCUM.
  - spike_valid and iter_done are ignored.
- ACCUM:
  - spike_valid && spike && spike_class < NUM_CLASSES: count[spike_class] += 1, saturating at 2^COUNT_W - 1 (no wrap).
  - spike_valid && spike_class >= NUM_CLASSES: no count change, err <= 1.
  - spike=0 with spike_valid: no change.
  - iter_done=1: iter_cnt += 1. If the incremented value == iter_lat, go to ARGMAX with scan index 0.
  - If spike_valid and iter_done are high in the same cycle, the spike is counted, then the transition applies.
  - start is ignored.
- ARGMAX:
  - One class per cycle, idx = 0..NUM_CLASSES-1.
  - idx 0: best = count[0], best_idx = 0, tie = 0.
  - idx > 0:
    - count[idx] > best: best = count[idx], best_idx = idx, tie = 0.
    - count[idx] == best: tie = 1.
    - otherwise no change.
  - Ties resolve to the lowest index.
  - After idx NUM_CLASSES-1 is evaluated, go to HOLD.
  - Inputs other than reset are ignored.
- Latency: iter_done is sampled at edge E0. label_valid is high after edge E0 + NUM_CLASSES + 1, which is 11 edges for default parameters.
- HOLD:
  - label_valid = 1; label = best_idx, label_count = best, and tie are stable.
  - label_valid stays high until label_ready = 1 is sampled. On that edge label_valid clears and the state goes to IDLE.
  - label, label_count, tie and err keep their values until the next accepted start.
  - start is ignored in HOLD, even if it arrives in the handshake cycle.
- err is sticky through HOLD and cleared only by an accepted start or reset.

Test Plan:
1. iter_num=2; over 2 passes fire class 3 twice, class 7 once, others 0 -> label=3, label_count=2, tie=0, err=0, label_valid exactly 11 edges after the 2nd iter_done.
2. iter_num=1; classes 2 and 5 each fire once -> label=2, label_count=1, tie=1.
3. Saturation: iter_num=255, class 0 fires every pass, COUNT_W=8 -> label=0, label_count=255, no wrap to 0.
4. spike_class=12 with spike_valid=1, plus class 4 firing once, iter_num=1 -> err=1, label=4, and counters for classes 0..9 otherwise unaffected.
5. Hold label_ready=0 for 5 cycles after label_valid -> label and label_valid stable for all 5 cycles; start pulsed during HOLD is ignored. label_ready=1 -> IDLE on the next edge; a following start accepted with counters cleared.
6. Assert reset mid-ACCUM after 3 counted spikes, then run iter_num=1 with no spikes -> all outputs 0 after reset; result label=0, label_count=0, tie=1.

Source files
------------

// File: rtl/spike_vote_classifier.sv
// Accumulates per-class spike votes over N stochastic passes, then scans for the argmax label.
// Latency: label_valid rises NUM_CLASSES+1 edges after the final iter_done is sampled.
// Backpressure: result held stable in HOLD until label_ready is sampled high; no new image until then.
module spike_vote_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int CLASS_W     = 4,
    parameter int COUNT_W     = 8,
    parameter int ITER_W      = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [ITER_W-1:0]  iter_num,
    input  logic               spike_valid,
    input  logic               spike,
    input  logic [CLASS_W-1:0] spike_class,
    input  logic               iter_done,
    output logic               busy,
    output logic               label_valid,
    input  logic               label_ready,
    output logic [CLASS_W-1:0] label,
    output logic [COUNT_W-1:0] label_count,
    output logic               tie,
    output logic               err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_ARGMAX = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // The scan index runs one step past the last class: that extra step commits the result.
    localparam int SCAN_W = $clog2(NUM_CLASSES + 1);
    localparam logic [SCAN_W-1:0]  SCAN_DONE = SCAN_W'(NUM_CLASSES);
    localparam logic [SCAN_W-1:0]  SCAN_ONE  = SCAN_W'(1);
    localparam logic [CLASS_W:0]   CLASS_LIM = (CLASS_W + 1)'(NUM_CLASSES);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);
    localparam logic [ITER_W-1:0]  ITER_ONE  = ITER_W'(1);

    logic [1:0]         state;
    logic [COUNT_W-1:0] count [NUM_CLASSES];
    logic [ITER_W-1:0]  iter_lat;
    logic [ITER_W-1:0]  iter_cnt;
    logic [ITER_W-1:0]  iter_cnt_inc;
    logic [SCAN_W-1:0]  scan_idx;
    logic [COUNT_W-1:0] scan_count;
    logic [COUNT_W-1:0] best;
    logic [CLASS_W-1:0] best_idx;
    logic               best_tie;
    logic               spike_in_range;

    assign busy           = (state == ST_ACCUM) || (state == ST_ARGMAX);
    assign spike_in_range = ({1'b0, spike_class} < CLASS_LIM);
    assign iter_cnt_inc   = iter_cnt + ITER_ONE;

    // Select the counter currently under the argmax scan (zero once past the last class).
    always_comb begin
        scan_count = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (scan_idx == SCAN_W'(i)) begin
                scan_count = count[i];
            end
        end
    end

    // Per-class saturating vote counters, cleared on reset and on an accepted start.
    always_ff @(posedge clock) begin
        if (reset || (state == ST_IDLE && start)) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                count[i] <= '0;
            end
        end else if (state == ST_ACCUM && spike_valid && spike && spike_in_range) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (spike_class == CLASS_W'(i) && count[i] != COUNT_MAX) begin
                    count[i] <= count[i] + COUNT_ONE;
                end
            end
        end
    end

    // Control FSM: iteration tracking, sequential argmax scan, result hold and handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            iter_lat    <= '0;
            iter_cnt    <= '0;
            scan_idx    <= '0;
            best        <= '0;
            best_idx    <= '0;
            best_tie    <= 1'b0;
            label_valid <= 1'b0;
            label       <= '0;
            label_count <= '0;
            tie         <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // A zero iteration count would never terminate; treat it as one pass.
                        iter_lat    <= (iter_num == '0) ? ITER_ONE : iter_num;
                        iter_cnt    <= '0;
                        scan_idx    <= '0;
                        best        <= '0;
                        best_idx    <= '0;
                        best_tie    <= 1'b0;
                        label       <= '0;
                        label_count <= '0;
                        tie         <= 1'b0;
                        err         <= 1'b0;
                        state       <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (spike_valid && !spike_in_range) begin
                        err <= 1'b1;
                    end
                    if (iter_done) begin
                        iter_cnt <= iter_cnt_inc;
                        if (iter_cnt_inc == iter_lat) begin
                            scan_idx <= '0;
                            state    <= ST_ARGMAX;
                        end
                    end
                end
                ST_ARGMAX: begin
                    if (scan_idx == SCAN_DONE) begin
                        label       <= best_idx;
                        label_count <= best;
                        tie         <= best_tie;
                        label_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end else begin
                        // Strict greater-than keeps the lowest index on equal counts.
                        if (scan_idx == '0) begin
                            best     <= scan_count;
                            best_idx <= '0;
                            best_tie <= 1'b0;
                        end else if (scan_count > best) begin
                            best     <= scan_count;
                            best_idx <= CLASS_W'(scan_idx);
                            best_tie <= 1'b0;
                        end else if (scan_count == best) begin
                            best_tie <= 1'b1;
                        end
                        scan_idx <= scan_idx + SCAN_ONE;
                    end
                end
                ST_HOLD: begin
                    if (label_ready) begin
                        label_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_vote_classifier.sv
// Directed bench for spike_vote_classifier: vote counting, argmax, ties, saturation, err, hold and reset.
// Latency of the result is measured from the edge that samples the final iter_done.
// Backpressure exercised by holding label_ready low while the result sits in HOLD.
module tb_spike_vote_classifier;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] iter_num = '0;
    logic       spike_valid = 1'b0;
    logic       spike = 1'b0;
    logic [3:0] spike_class = '0;
    logic       iter_done = 1'b0;
    logic       busy;
    logic       label_valid;
    logic       label_ready = 1'b0;
    logic [3:0] label;
    logic [7:0] label_count;
    logic       tie;
    logic       err;

    int checks = 0;
    int errors = 0;

    spike_vote_classifier #(
        .NUM_CLASSES(10),
        .CLASS_W(4),
        .COUNT_W(8),
        .ITER_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .iter_num(iter_num),
        .spike_valid(spike_valid),
        .spike(spike),
        .spike_class(spike_class),
        .iter_done(iter_done),
        .busy(busy),
        .label_valid(label_valid),
        .label_ready(label_ready),
        .label(label),
        .label_count(label_count),
        .tie(tie),
        .err(err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [7:0] n);
        start = 1'b1; iter_num = n;
        tick();
        start = 1'b0; iter_num = '0;
    endtask

    task automatic spike_cycle(input logic [3:0] cls, input logic fire, input logic done);
        spike_valid = 1'b1; spike = fire; spike_class = cls; iter_done = done;
        tick();
        spike_valid = 1'b0; spike = 1'b0; spike_class = '0; iter_done = 1'b0;
    endtask

    task automatic pass_done();
        iter_done = 1'b1;
        tick();
        iter_done = 1'b0;
    endtask

    // Counts edges from the final iter_done edge until label_valid; -1 if the budget expires.
    task automatic wait_label(input bit noise, output int edges);
        edges = -1;
        if (noise) begin
            spike_valid = 1'b1; spike = 1'b1; spike_class = 4'd5; iter_done = 1'b1;
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (label_valid) begin
                edges = k;
                break;
            end
        end
        spike_valid = 1'b0; spike = 1'b0; spike_class = '0; iter_done = 1'b0;
    endtask

    task automatic handshake();
        label_ready = 1'b1;
        tick();
        label_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (label_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", label_valid); end
        checks++; if (label !== 4'd0) begin errors++; $display("FAIL reset_label got %0d want 0", label); end
        checks++; if (label_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", label_count); end
        checks++; if (tie !== 1'b0) begin errors++; $display("FAIL reset_tie got %0b want 0", tie); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
    endtask

    task automatic test_basic();
        int e;
        do_start(8'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b want 1", busy); end
        // start while accumulating must not relatch the iteration count
        do_start(8'd5);
        spike_cycle(4'd3, 1'b1, 1'b0);
        spike_cycle(4'd7, 1'b1, 1'b0);
        spike_cycle(4'd1, 1'b0, 1'b0);
        pass_done();
        spike_cycle(4'd3, 1'b1, 1'b1);
        wait_label(1'b0, e);
        checks++; if (e !== 11) begin errors++; $display("FAIL basic_latency got %0d want 11", e); end
        checks++; if (label !== 4'd3) begin errors++; $display("FAIL basic_label got %0d want 3", label); end
        checks++; if (label_count !== 8'd2) begin errors++; $display("FAIL basic_count got %0d want 2", label_count); end
        checks++; if (tie !== 1'b0) begin errors++; $display("FAIL basic_tie got %0b want 0", tie); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %0b want 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_hold_busy got %0b want 0", busy); end
        handshake();
        checks++; if (label_valid !== 1'b0) begin errors++; $display("FAIL basic_ack got %0b want 0", label_valid); end
    endtask

    task automatic test_tie();
        int e;
        do_start(8'd1);
        spike_cycle(4'd5, 1'b1, 1'b0);
        spike_cycle(4'd2, 1'b1, 1'b0);
        pass_done();
        // spikes on class 5 during the scan must be ignored
        wait_label(1'b1, e);
        checks++; if (e !== 11) begin errors++; $display("FAIL tie_latency got %0d want 11", e); end
        checks++; if (label !== 4'd2) begin errors++; $display("FAIL tie_label got %0d want 2", label); end
        checks++; if (label_count !== 8'd1) begin errors++; $display("FAIL tie_count got %0d want 1", label_count); end
        checks++; if (tie !== 1'b1) begin errors++; $display("FAIL tie_flag got %0b want 1", tie); end
        handshake();
    endtask

    task automatic test_iter_zero();
        int e;
        do_start(8'd0);
        spike_cycle(4'd9, 1'b1, 1'b1);
        wait_label(1'b0, e);
        checks++; if (e !== 11) begin errors++; $display("FAIL zero_latency got %0d want 11", e); end
        checks++; if (label !== 4'd9) begin errors++; $display("FAIL zero_label got %0d want 9", label); end
        checks++; if (label_count !== 8'd1) begin errors++; $display("FAIL zero_count got %0d want 1", label_count); end
        checks++; if (tie !== 1'b0) begin errors++; $display("FAIL zero_tie got %0b want 0", tie); end
        handshake();
    endtask

    task automatic test_saturation();
        int e;
        do_start(8'd255);
        for (int p = 0; p < 255; p++) begin
            spike_cycle(4'd0, 1'b1, 1'b0);
            spike_cycle(4'd0, 1'b1, 1'b1);
        end
        wait_label(1'b0, e);
        checks++; if (e !== 11) begin errors++; $display("FAIL sat_latency got %0d want 11", e); end
        checks++; if (label !== 4'd0) begin errors++; $display("FAIL sat_label got %0d want 0", label); end
        checks++; if (label_count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d want 255", label_count); end
        checks++; if (tie !== 1'b0) begin errors++; $display("FAIL sat_tie got %0b want 0", tie); end
        handshake();
    endtask

    task automatic test_err();
        int e;
        do_start(8'd1);
        spike_cycle(4'd12, 1'b1, 1'b0);
        spike_cycle(4'd15, 1'b0, 1'b0);
        spike_cycle(4'd4, 1'b1, 1'b0);
        pass_done();
        wait_label(1'b0, e);
        checks++; if (e !== 11) begin errors++; $display("FAIL err_latency got %0d want 11", e); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag got %0b want 1", err); end
        checks++; if (label !== 4'd4) begin errors++; $display("FAIL err_label got %0d want 4", label); end
        checks++; if (label_count !== 8'd1) begin errors++; $display("FAIL err_count got %0d want 1", label_count); end
        checks++; if (tie !== 1'b0) begin errors++; $display("FAIL err_tie got %0b want 0", tie); end
        handshake();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky_idle got %0b want 1", err); end
        checks++; if (label !== 4'd4) begin errors++; $display("FAIL err_label_kept got %0d want 4", label); end
        do_start(8'd1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got %0b want 0", err); end
        pass_done();
        wait_label(1'b0, e);
        handshake();
    endtask

    task automatic test_hold();
        int e;
        do_start(8'd1);
        spike_cycle(4'd6, 1'b1, 1'b0);
        spike_cycle(4'd6, 1'b1, 1'b0);
        spike_cycle(4'd8, 1'b1, 1'b1);
        wait_label(1'b0, e);
        checks++; if (e !== 11) begin errors++; $display("FAIL hold_latency got %0d want 11", e); end
        for (int c = 0; c < 5; c++) begin
            label_ready = 1'b0;
            start = (c == 2); iter_num = 8'd3;
            tick();
            start = 1'b0; iter_num = '0;
            checks++; if (label_valid !== 1'b1) begin errors++; $display("FAIL hold_valid_%0d got %0b want 1", c, label_valid); end
            checks++; if (label !== 4'd6) begin errors++; $display("FAIL hold_label_%0d got %0d want 6", c, label); end
            checks++; if (label_count !== 8'd2) begin errors++; $display("FAIL hold_count_%0d got %0d want 2", c, label_count); end
        end
        // start in the handshake cycle is also ignored
        label_ready = 1'b1; start = 1'b1; iter_num = 8'd1;
        tick();
        label_ready = 1'b0; start = 1'b0; iter_num = '0;
        checks++; if (label_valid !== 1'b0) begin errors++; $display("FAIL hold_ack got %0b want 0", label_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_start_ignored got %0b want 0", busy); end
        checks++; if (label !== 4'd6) begin errors++; $display("FAIL hold_label_kept got %0d want 6", label); end
        do_start(8'd1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_restart got %0b want 1", busy); end
        pass_done();
        wait_label(1'b0, e);
        checks++; if (label_count !== 8'd0) begin errors++; $display("FAIL hold_cleared_count got %0d want 0", label_count); end
        checks++; if (tie !== 1'b1) begin errors++; $display("FAIL hold_cleared_tie got %0b want 1", tie); end
        handshake();
    endtask

    task automatic test_reset_mid();
        int e;
        do_start(8'd3);
        spike_cycle(4'd1, 1'b1, 1'b0);
        spike_cycle(4'd1, 1'b1, 1'b0);
        spike_cycle(4'd1, 1'b1, 1'b0);
        spike_cycle(4'd13, 1'b1, 1'b0);
        pass_done();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b want 0", busy); end
        checks++; if (label_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0b want 0", label_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_err got %0b want 0", err); end
        checks++; if (label_count !== 8'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", label_count); end
        do_start(8'd1);
        pass_done();
        wait_label(1'b0, e);
        checks++; if (e !== 11) begin errors++; $display("FAIL rmid_latency got %0d want 11", e); end
        checks++; if (label !== 4'd0) begin errors++; $display("FAIL rmid_label got %0d want 0", label); end
        checks++; if (label_count !== 8'd0) begin errors++; $display("FAIL rmid_res_count got %0d want 0", label_count); end
        checks++; if (tie !== 1'b1) begin errors++; $display("FAIL rmid_tie got %0b want 1", tie); end
        handshake();
        // reset while a nonzero result is held
        do_start(8'd1);
        spike_cycle(4'd9, 1'b1, 1'b1);
        wait_label(1'b0, e);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (label_valid !== 1'b0) begin errors++; $display("FAIL rhold_valid got %0b want 0", label_valid); end
        checks++; if (label !== 4'd0) begin errors++; $display("FAIL rhold_label got %0d want 0", label); end
        checks++; if (label_count !== 8'd0) begin errors++; $display("FAIL rhold_count got %0d want 0", label_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_iter_zero();
        test_saturation();
        test_err();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
